// File: rtl/down_timer_if.sv
// down_timer_if: control and status bundle between a timer user and the down_timer
interface down_timer_if #(parameter int WIDTH = 8);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             tick;
  logic             auto_reload;
  logic [WIDTH-1:0] cnt;
  logic             running;
  logic             zero;
  logic             expired;
  modport master (output clr, load, load_val, start, stop, tick, auto_reload,
                  input cnt, running, zero, expired);
  modport slave  (input clr, load, load_val, start, stop, tick, auto_reload,
                  output cnt, running, zero, expired);
endinterface

// File: rtl/down_timer.sv
// down_timer: prescaled down counter with start/stop/hold, one-shot or auto-reload expiry
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  down_timer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic [7:0]       PSC_MAX = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic [7:0]       psc_q, psc_d;
  logic             exp_q, exp_d;
  logic             running_q, running_d;
  // next state: clr > load > stop > start > tick-driven decrement
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    psc_d   = psc_q;
    exp_d   = 1'b0;
    if (bus.clr) begin
      cnt_d   = '0;
      psc_d   = '0;
      state_d = IDLE;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
      rld_d = bus.load_val;
      psc_d = '0;
    end else if (bus.stop) begin
      state_d = (state_q == RUN) ? HOLD : state_q;
    end else if (bus.start && state_q != RUN) begin
      state_d = (cnt_q != '0) ? RUN : state_q;
    end else if (state_q == RUN) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else if (bus.tick) begin
        if (psc_q == PSC_MAX) begin
          psc_d = '0;
          exp_d = (cnt_q == ONE);
          if (cnt_q != ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (bus.auto_reload && rld_q != '0) begin
            cnt_d = rld_q;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          psc_d = psc_q + 8'd1;
        end
      end
    end
    running_d = (state_d == RUN);
  end
  // state register, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rld_q     <= '0;
      psc_q     <= '0;
      exp_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
      psc_q     <= psc_d;
      exp_q     <= exp_d;
      running_q <= running_d;
    end
  end
  assign bus.cnt     = cnt_q;
  assign bus.running = running_q;
  assign bus.zero    = (cnt_q == '0);
  assign bus.expired = exp_q;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed scenarios against two timers (prescale 1 and 4) with a queued scoreboard
module tb_down_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  localparam logic [5:0] C = 6'b100000, L = 6'b010000, S = 6'b001000,
                         P = 6'b000100, T = 6'b000010, A = 6'b000001, N = 6'b000000;
  typedef struct packed {logic [7:0] c; logic r; logic e;} exp_t;
  exp_t sb[$];
  down_timer_if #(.WIDTH(8)) i1 ();
  down_timer_if #(.WIDTH(8)) i4 ();
  down_timer #(.WIDTH(8), .PRESCALE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  down_timer #(.WIDTH(8), .PRESCALE(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic s4, input logic [5:0] c, input logic [7:0] lv);
    {i1.clr, i1.load, i1.start, i1.stop, i1.tick, i1.auto_reload} = s4 ? N : c;
    {i4.clr, i4.load, i4.start, i4.stop, i4.tick, i4.auto_reload} = s4 ? c : N;
    i1.load_val = lv;
    i4.load_val = lv;
  endtask
  task automatic step(input logic s4, input logic [5:0] c, input logic [7:0] lv,
                      input logic [7:0] ec, input logic er, input logic ee, input string tag);
    exp_t e;
    logic [7:0] oc;
    logic orr, oe, oz;
    drive(s4, c, lv);
    sb.push_back({ec, er, ee});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    oc  = s4 ? i4.cnt : i1.cnt;
    orr = s4 ? i4.running : i1.running;
    oe  = s4 ? i4.expired : i1.expired;
    oz  = s4 ? i4.zero : i1.zero;
    chk({tag, "_cnt"}, 32'(oc), 32'(e.c));
    chk({tag, "_running"}, 32'(orr), 32'(e.r));
    chk({tag, "_expired"}, 32'(oe), 32'(e.e));
    chk({tag, "_zero"}, 32'(oz), 32'(e.c == 8'd0));
  endtask
  initial begin
    drive(1'b0, N, 8'd0);
    #12;
    chk("rst_cnt", 32'(i1.cnt), 0);
    chk("rst_running", 32'(i1.running), 0);
    chk("rst_expired", 32'(i1.expired), 0);
    chk("rst_zero", 32'(i1.zero), 1);
    chk("rst4_cnt", 32'(i4.cnt), 0);
    rst_n = 1'b1;
    step(0, S, 0, 0, 0, 0, "start_at_zero");
    step(0, L, 3, 3, 0, 0, "os_load");
    step(0, S, 0, 3, 1, 0, "os_start");
    step(0, T, 0, 2, 1, 0, "os_d2");
    step(0, T, 0, 1, 1, 0, "os_d1");
    step(0, T, 0, 0, 0, 1, "os_expire");
    step(0, T, 0, 0, 0, 0, "os_nowrap");
    step(0, S, 0, 0, 0, 0, "os_restart_zero");
    step(0, L | A, 2, 2, 0, 0, "ar_load");
    step(0, S | A, 0, 2, 1, 0, "ar_start");
    step(0, T | A, 0, 1, 1, 0, "ar_d1");
    step(0, T | A, 0, 2, 1, 1, "ar_reload1");
    step(0, T | A, 0, 1, 1, 0, "ar_d1b");
    step(0, T | A, 0, 2, 1, 1, "ar_reload2");
    step(0, P, 0, 2, 0, 0, "ar_stop");
    step(0, C, 0, 0, 0, 0, "ar_clr");
    step(0, L | A, 1, 1, 0, 0, "b2b_load");
    step(0, S | A, 0, 1, 1, 0, "b2b_start");
    for (int i = 0; i < 3; i++) step(0, T | A, 0, 1, 1, 1, "b2b_pulse");
    step(0, C, 0, 0, 0, 0, "b2b_clr");
    step(0, L, 5, 5, 0, 0, "pz_load");
    step(0, S, 0, 5, 1, 0, "pz_start");
    step(0, T, 0, 4, 1, 0, "pz_d4");
    step(0, T, 0, 3, 1, 0, "pz_d3");
    step(0, P | T, 0, 3, 0, 0, "pz_stop");
    for (int i = 0; i < 10; i++) step(0, T, 0, 3, 0, 0, "pz_hold");
    step(0, S | T, 0, 3, 1, 0, "pz_resume");
    step(0, T, 0, 2, 1, 0, "pz_d2");
    step(0, T, 0, 1, 1, 0, "pz_d1");
    step(0, T, 0, 0, 0, 1, "pz_expire");
    step(0, L, 2, 2, 0, 0, "col_load");
    step(0, S, 0, 2, 1, 0, "col_start");
    step(0, T, 0, 1, 1, 0, "col_d1");
    step(0, L | T, 7, 7, 1, 0, "col_load7");
    step(0, T, 0, 6, 1, 0, "col_d6");
    step(0, P, 0, 6, 0, 0, "col_stop");
    step(0, L, 1, 1, 0, 0, "clrcol_load");
    step(0, S, 0, 1, 1, 0, "clrcol_start");
    step(0, C | T, 0, 0, 0, 0, "clrcol_clr");
    step(0, L, 3, 3, 0, 0, "z_load");
    step(0, S, 0, 3, 1, 0, "z_start");
    step(0, L, 0, 0, 1, 0, "z_load0");
    step(0, N, 0, 0, 0, 0, "z_idle");
    step(0, L, 5, 5, 0, 0, "rs_load");
    step(0, S, 0, 5, 1, 0, "rs_start");
    step(0, T, 0, 4, 1, 0, "rs_d4");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_async_cnt", 32'(i1.cnt), 0);
    chk("rs_async_running", 32'(i1.running), 0);
    chk("rs_async_expired", 32'(i1.expired), 0);
    #1;
    rst_n = 1'b1;
    step(0, S, 0, 0, 0, 0, "rs_start_ignored");
    step(0, L, 2, 2, 0, 0, "rs_reload");
    step(0, S, 0, 2, 1, 0, "rs_start_ok");
    step(1, L, 2, 2, 0, 0, "ps_load");
    step(1, S, 0, 2, 1, 0, "ps_start");
    for (int i = 0; i < 3; i++) step(1, T, 0, 2, 1, 0, "ps_hold2");
    step(1, T, 0, 1, 1, 0, "ps_d1");
    for (int i = 0; i < 3; i++) step(1, T, 0, 1, 1, 0, "ps_hold1");
    step(1, T, 0, 0, 0, 1, "ps_expire");
    step(1, T, 0, 0, 0, 0, "ps_after");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
